// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage: owns HI/LO, runs WIDTH-step
// shift-add multiply and restoring divide, and holds busy until the result commits.
module alu_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [4:0]       alu_ctrl_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [4:0] OpMfhi  = 5'd16;
    localparam logic [4:0] OpMthi  = 5'd17;
    localparam logic [4:0] OpMflo  = 5'd18;
    localparam logic [4:0] OpMtlo  = 5'd19;
    localparam logic [4:0] OpMult  = 5'd24;
    localparam logic [4:0] OpMultu = 5'd25;
    localparam logic [4:0] OpDiv   = 5'd26;
    localparam logic [4:0] OpDivu  = 5'd27;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   raw_a_q, raw_a_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               signed_q, signed_d;
    logic               is_div_q, is_div_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               op_signed;
    logic               op_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        op_signed = (alu_ctrl_i == OpMult) || (alu_ctrl_i == OpDiv);
        op_div    = (alu_ctrl_i == OpDiv) || (alu_ctrl_i == OpDivu);
        a_mag     = (op_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag     = (op_signed && b_i[WIDTH-1]) ? -b_i : b_i;
        // Multiply: upper half accumulates, lower half holds the remaining multiplier bits.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        // Divide: trial subtraction on the remainder shifted left with the next dividend bit.
        div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        prod_fix  = (signed_q && (sa_q ^ sb_q)) ? -acc_q : acc_q;
        quot      = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        raw_a_d  = raw_a_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        signed_d = signed_q;
        is_div_d = is_div_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !cancel_i) begin
                    case (alu_ctrl_i)
                        OpMult, OpMultu, OpDiv, OpDivu: begin
                            state_d  = op_div ? StDiv : StMul;
                            cnt_d    = '0;
                            sa_d     = op_signed & a_i[WIDTH-1];
                            sb_d     = op_signed & b_i[WIDTH-1];
                            signed_d = op_signed;
                            is_div_d = op_div;
                            dbz_d    = (b_i == '0);
                            raw_a_d  = a_i;
                            if (op_div) begin
                                acc_d  = {{WIDTH{1'b0}}, a_mag};
                                opnd_d = b_mag;
                            end else begin
                                acc_d  = {{WIDTH{1'b0}}, b_mag};
                                opnd_d = a_mag;
                            end
                        end
                        OpMthi: begin
                            hi_d   = a_i;
                            done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d   = a_i;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StMul: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StDiv: begin
                if (!div_trial[WIDTH]) begin
                    acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (dbz_q) begin
                    lo_d = {WIDTH{1'b1}};
                    hi_d = raw_a_q;
                end else begin
                    lo_d = (signed_q && (sa_q ^ sb_q)) ? -quot : quot;
                    hi_d = (signed_q && sa_q) ? -rem : rem;
                end
            end
            default: state_d = StIdle;
        endcase

        // A flush abandons the operation without touching HI/LO.
        if (cancel_i && (state_q != StIdle)) begin
            state_d = StIdle;
            done_d  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            raw_a_q  <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            signed_q <= 1'b0;
            is_div_q <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            raw_a_q  <= raw_a_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            signed_q <= signed_d;
            is_div_q <= is_div_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        result_o = '0;
        if (alu_ctrl_i == OpMfhi) begin
            result_o = hi_q;
        end else if (alu_ctrl_i == OpMflo) begin
            result_o = lo_q;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit: directed and random mul/div against an
// arithmetic reference, plus MTHI/MTLO, ignored start, cancel and async reset.
module tb_alu_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  alu_ctrl = 5'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    alu_muldiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .alu_ctrl_i (alu_ctrl),
        .a_i        (a),
        .b_i        (b),
        .cancel_i   (cancel),
        .busy_o     (busy),
        .done_o     (done),
        .hi_o       (hi),
        .lo_o       (lo),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic with MIPS truncating division.
    function automatic void ref_op(input logic [4:0] ctrl, input logic [31:0] ra,
                                   input logic [31:0] rb, output logic [31:0] rhi,
                                   output logic [31:0] rlo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        rhi = '0;
        rlo = '0;
        case (ctrl)
            5'd24: begin p = 64'(sa * sb); {rhi, rlo} = p; end
            5'd25: begin p = {32'b0, ra} * {32'b0, rb}; {rhi, rlo} = p; end
            5'd26, 5'd27: begin
                if (rb == 0) begin
                    rlo = 32'hFFFF_FFFF;
                    rhi = ra;
                end else if (ctrl == 5'd26) begin
                    q = sa / sb;
                    r = sa % sb;
                    rlo = q[31:0];
                    rhi = r[31:0];
                end else begin
                    rlo = ra / rb;
                    rhi = ra % rb;
                end
            end
            default: ;
        endcase
    endfunction

    // Issues one mul/div op and waits (bounded) for done; reports latency and busy cycles.
    task automatic do_op(input logic [4:0] ctrl, input logic [31:0] va, input logic [31:0] vb,
                         output int lat, output int busy_cnt);
        @(negedge clk);
        start = 1'b1;
        alu_ctrl = ctrl;
        a = va;
        b = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        alu_ctrl = 5'd16;
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++;
        if ({hi, lo} !== 64'd0) begin
            fails++; $display("FAIL reset_hilo got %h_%h want 0", hi, lo);
        end
        tests++;
        if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [4:0]  ctrl_t [9] = '{5'd25, 5'd24, 5'd24, 5'd27, 5'd26, 5'd26, 5'd27, 5'd26,
                                    5'd26};
        logic [31:0] a_t  [9] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'd100,
                                  32'hFFFFFFF9, 32'd7, 32'd5, 32'h80000000, 32'hFFFFFFF9};
        logic [31:0] b_t  [9] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd7, 32'd2,
                                  32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd0};
        logic [31:0] hi_t [9] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'd2,
                                  32'hFFFFFFFF, 32'd1, 32'd5, 32'd0, 32'hFFFFFFF9};
        logic [31:0] lo_t [9] = '{32'h00000001, 32'hFFFFFFEB, 32'd0, 32'd14, 32'hFFFFFFFD,
                                  32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        int lat, bc;
        for (int i = 0; i < 9; i++) begin
            do_op(ctrl_t[i], a_t[i], b_t[i], lat, bc);
            tests++;
            if (lat != 33 || bc != 33) begin
                fails++;
                $display("FAIL dir%0d_timing got lat=%0d busy=%0d want 33/33", i, lat, bc);
            end
            tests++;
            if (hi !== hi_t[i] || lo !== lo_t[i]) begin
                fails++;
                $display("FAIL dir%0d_value got %h_%h want %h_%h", i, hi, lo, hi_t[i], lo_t[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        logic [4:0]  ctrl;
        logic [31:0] va, vb, ehi, elo;
        int lat, bc;
        for (int i = 0; i < 40; i++) begin
            ctrl = 5'(24 + $urandom_range(0, 3));
            va = ($urandom_range(0, 4) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            vb = ($urandom_range(0, 4) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) vb = vb >> $urandom_range(16, 31);
            ref_op(ctrl, va, vb, ehi, elo);
            do_op(ctrl, va, vb, lat, bc);
            tests++;
            if (lat != 33 || hi !== ehi || lo !== elo) begin
                fails++;
                $display("FAIL rnd%0d op=%0d a=%h b=%h got %h_%h lat=%0d want %h_%h lat=33",
                         i, ctrl, va, vb, hi, lo, lat, ehi, elo);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        start = 1'b1; alu_ctrl = 5'd17; a = 32'h12345678;
        @(posedge clk);
        #1;
        start = 1'b0;
        alu_ctrl = 5'd16;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            fails++; $display("FAIL mthi_flags got busy=%b done=%b want 0/1", busy, done);
        end
        tests++;
        if (result !== 32'h12345678) begin
            fails++; $display("FAIL mfhi_result got %h want 12345678", result);
        end
        @(negedge clk);
        start = 1'b1; alu_ctrl = 5'd19; a = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        start = 1'b0;
        alu_ctrl = 5'd18;
        #1;
        tests++;
        if (result !== 32'hCAFEF00D || hi !== 32'h12345678 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mtlo got lo=%h hi=%h busy=%b want cafef00d 12345678 0", result, hi,
                     busy);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL mt_done_pulse got %b want 0", done); end
    endtask

    task automatic test_ignore_start();
        logic [31:0] ehi, elo;
        int lat;
        ref_op(5'd24, 32'hFFFF1234, 32'h00005678, ehi, elo);
        @(negedge clk);
        start = 1'b1; alu_ctrl = 5'd24; a = 32'hFFFF1234; b = 32'h00005678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; alu_ctrl = 5'd27; a = 32'd100; b = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 6;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests++;
        if (lat != 33 || hi !== ehi || lo !== elo) begin
            fails++;
            $display("FAIL ignore_start got %h_%h lat=%0d want %h_%h lat=33", hi, lo, lat, ehi,
                     elo);
        end
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL ignore_start_idle got busy=%b", busy); end
    endtask

    task automatic test_cancel();
        logic [31:0] phi, plo;
        bit saw_done;
        phi = hi;
        plo = lo;
        @(negedge clk);
        start = 1'b1; alu_ctrl = 5'd25; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL cancel_busy got %b want 0", busy); end
        saw_done = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        tests++;
        if (saw_done) begin fails++; $display("FAIL cancel_done got 1 want 0"); end
        tests++;
        if (hi !== phi || lo !== plo) begin
            fails++; $display("FAIL cancel_hilo got %h_%h want %h_%h", hi, lo, phi, plo);
        end
    endtask

    task automatic test_async_reset();
        int lat, bc;
        @(negedge clk);
        start = 1'b1; alu_ctrl = 5'd26; a = 32'd1000; b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            fails++;
            $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h want all 0", busy, done,
                     hi, lo);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(5'd25, 32'd3, 32'd4, lat, bc);
        tests++;
        if (lat != 33 || hi !== 32'd0 || lo !== 32'd12) begin
            fails++;
            $display("FAIL post_reset_multu got %h_%h lat=%0d want 0_c lat=33", hi, lo, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_op(5'd27, 32'd1000, 32'd10, lat, bc);
        do_op(5'd24, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
        tests++;
        if (lat != 33 || bc != 33 || hi !== 32'd0 || lo !== 32'd1) begin
            fails++;
            $display("FAIL back_to_back got %h_%h lat=%0d busy=%0d want 0_1 33/33", hi, lo, lat,
                     bc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_ignore_start();
        test_cancel();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
